booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_seq.sv | 104 ++++++++++
 tb/tb_booth_mul_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product.
// Operands are widened by one bit so the same signed datapath also handles unsigned mode.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E);
  localparam logic [CW-1:0] LAST = CW'(E - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [E-1:0]   acc, q, m;
  logic           qm1;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic [E-1:0]   m_ext, q_ext;
  logic [E-1:0]   sum, acc_sh, q_sh;

  assign m_ext = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
  assign q_ext = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A new operation may be accepted from DONE as well as IDLE, giving back-to-back issue.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_sh = {sum[E-1], sum[E-1:1]};
    q_sh   = {sum[0], q[E-1:1]};
  end

  // The top two bits of the shifted accumulator are pure sign copies and never reach product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc <= '0;
      q   <= q_ext;
      qm1 <= 1'b0;
      m   <= m_ext;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_sh;
      q   <= q_sh;
      qm1 <= q[0];
      cnt <= cnt + CW'(1);
      if (cnt == LAST) product <= {acc_sh[E-3:0], q_sh};
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: a WIDTH=4 and a WIDTH=8 instance, each with its own
// expected-product and expected-done-cycle queues popped by a monitor on every done pulse.
module tb_booth_mul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0, sg4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;
  logic       busy4, done4;

  logic        start8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  exp4[$];
  int          due4[$];
  int          busy_run4 = 0;
  logic [15:0] exp8[$];
  int          due8[$];
  int          busy_run8 = 0;

  booth_mul_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sg4),
    .multiplicand(a4), .multiplier(b4), .product(p4), .busy(busy4), .done(done4)
  );

  booth_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sg8),
    .multiplicand(a8), .multiplier(b8), .product(p8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
    end
    return 16'({8'h00, a} * {8'h00, b});
  endfunction

  // Monitors: every done pulse must match the head of the queue, arrive on the predicted
  // cycle, and follow a busy run of exactly WIDTH+1 cycles.
  always @(negedge clk) begin
    if (busy4) begin
      busy_run4++;
    end else begin
      if (done4) begin
        if (exp4.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done4_unexpected: got done with product 0x%0h, required no done", p4);
        end else begin
          checkOutput("product4", p4, exp4.pop_front());
          checkOutput("latency4_cycle", cyc, due4.pop_front());
          checkOutput("busy4_run", busy_run4, 5);
        end
      end
      busy_run4 = 0;
    end
  end

  always @(negedge clk) begin
    if (busy8) begin
      busy_run8++;
    end else begin
      if (done8) begin
        if (exp8.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done8_unexpected: got done with product 0x%0h, required no done", p8);
        end else begin
          checkOutput("product8", p8, exp8.pop_front());
          checkOutput("latency8_cycle", cyc, due8.pop_front());
          checkOutput("busy8_run", busy_run8, 9);
        end
      end
      busy_run8 = 0;
    end
  end

  task automatic waitIdle4();
    int g = 0;
    while (busy4 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy4) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy4_timeout: got busy=1 after %0d cycles, required 0", g);
    end
  endtask

  task automatic waitIdle8();
    int g = 0;
    while (busy8 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy8) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy8_timeout: got busy=1 after %0d cycles, required 0", g);
    end
  endtask

  task automatic applyStimulus4(input logic s, input logic [3:0] a, input logic [3:0] b,
                                input logic [7:0] exp_p);
    waitIdle4();
    start4 = 1'b1;
    sg4    = s;
    a4     = a;
    b4     = b;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    exp4.push_back(exp_p);
    due4.push_back(cyc + 5);
  endtask

  task automatic applyStimulus8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] exp_p);
    waitIdle8();
    start8 = 1'b1;
    sg8    = s;
    a8     = a;
    b8     = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    exp8.push_back(exp_p);
    due8.push_back(cyc + 9);
  endtask

  // start stays high throughout; operands are scrambled every RUN cycle and the next
  // vector is presented in the DONE cycle, so accepts land every WIDTH+2 edges.
  task automatic backToBack4();
    logic [3:0] va[4];
    logic [3:0] vb[4];
    logic       vs[4];
    logic [7:0] vp[4];
    va = '{4'd3, 4'd6, 4'hF, 4'hF};
    vb = '{4'd3, 4'd7, 4'hF, 4'd1};
    vs = '{1'b1, 1'b0, 1'b1, 1'b0};
    vp = '{8'h09, 8'h2A, 8'h01, 8'h0F};
    waitIdle4();
    start4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sg4 = vs[i];
      a4  = va[i];
      b4  = vb[i];
      @(posedge clk);
      @(negedge clk);
      exp4.push_back(vp[i]);
      due4.push_back(cyc + 5);
      repeat (5) begin
        sg4 = 1'($urandom);
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
    end
    start4 = 1'b0;
  endtask

  task automatic resetMidOp4();
    waitIdle4();
    start4 = 1'b1;
    sg4    = 1'b1;
    a4     = 4'd5;
    b4     = 4'd5;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_product4", p4, 0);
    checkOutput("midreset_busy4", busy4, 0);
    checkOutput("midreset_done4", done4, 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int g;
    logic       s;
    logic [7:0] a, b;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_product4", p4, 0);
    checkOutput("reset_busy4", busy4, 0);
    checkOutput("reset_done4", done4, 0);
    checkOutput("reset_product8", p8, 0);
    checkOutput("reset_busy8", busy8, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus4(1'b1, 4'hD, 4'd5, 8'hF1);
    applyStimulus4(1'b1, 4'd2, 4'h9, 8'hF2);
    applyStimulus4(1'b1, 4'hC, 4'hE, 8'h08);
    applyStimulus4(1'b1, 4'h8, 4'h8, 8'h40);
    applyStimulus4(1'b1, 4'h8, 4'h7, 8'hC8);
    applyStimulus4(1'b0, 4'hF, 4'hF, 8'hE1);
    applyStimulus4(1'b0, 4'h8, 4'h0, 8'h00);
    applyStimulus4(1'b0, 4'h0, 4'h0, 8'h00);

    backToBack4();
    resetMidOp4();
    applyStimulus4(1'b1, 4'd3, 4'd3, 8'h09);

    applyStimulus8(1'b1, 8'h80, 8'h80, 16'h4000);
    applyStimulus8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    applyStimulus8(1'b1, 8'h7F, 8'h80, 16'hC080);
    applyStimulus8(1'b1, 8'hFF, 8'h02, 16'hFFFE);
    applyStimulus8(1'b0, 8'hFF, 8'h02, 16'h01FE);
    for (int i = 0; i < 2000; i++) begin
      s = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      applyStimulus8(s, a, b, ref8(s, a, b));
    end

    g = 0;
    while ((exp4.size() != 0 || exp8.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("drain4_pending", exp4.size(), 0);
    checkOutput("drain8_pending", exp8.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
